// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the RAM access controller.
package ram_ctrl_pkg;

    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_AW    = 8;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdIssue,
        StRdWait,
        StResp,
        StFill
    } state_t;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM with registered read data; every word resets to all-ones.
module single_port_ram #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] idx;
    logic          hit;

    assign idx = adr[IW-1:0];
    assign hit = 32'(adr) < DEPTH;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '1;
            end
            dout <= '1;
        end else if (ce && hit) begin
            if (we) begin
                mem[idx] <= din;
            end else begin
                dout <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Command/response front end for a single-port RAM, with a background fill engine.
// One command outstanding at a time; all outputs are registered.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_pattern,
    output logic          busy,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    state_t        state;
    logic [AW-1:0] fill_cnt;
    logic          in_range;

    // Full-width compare: addresses beyond DEPTH never alias onto real words.
    assign in_range = 32'(req_addr) < DEPTH;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= StIdle;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_adr   <= '0;
            ram_din   <= '0;
            fill_cnt  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (fill_start) begin
                        // Fill wins over a simultaneous command; the command waits.
                        state     <= StFill;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        ram_ce    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_adr   <= '0;
                        ram_din   <= fill_pattern;
                        fill_cnt  <= '0;
                    end else if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (!in_range) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_we    <= req_we;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            state   <= StWr;
                            ram_ce  <= 1'b1;
                            ram_we  <= 1'b1;
                            ram_adr <= req_addr;
                            ram_din <= req_wdata;
                        end else begin
                            state   <= StRdIssue;
                            ram_ce  <= 1'b1;
                            ram_we  <= 1'b0;
                            ram_adr <= req_addr;
                        end
                    end
                end
                StWr: begin
                    state     <= StResp;
                    ram_ce    <= 1'b0;
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                StRdIssue: begin
                    state  <= StRdWait;
                    ram_ce <= 1'b0;
                    ram_we <= 1'b0;
                end
                StRdWait: begin
                    state     <= StResp;
                    rsp_valid <= 1'b1;
                    rsp_we    <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ram_dout;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                StFill: begin
                    if (fill_cnt == AW'(DEPTH - 1)) begin
                        state     <= StIdle;
                        fill_cnt  <= '0;
                        ram_ce    <= 1'b0;
                        ram_we    <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                        ram_adr  <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    ram_ce    <= 1'b0;
                    ram_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench: driver pushes expected responses, monitor pops at each response handshake.
module tb_ram_access_ctrl;
    import ram_ctrl_pkg::*;

    localparam int unsigned DW    = DEF_DW;
    localparam int unsigned AW    = DEF_AW;
    localparam int unsigned DEPTH = DEF_DEPTH;

    typedef struct {
        logic          we;
        logic          err;
        logic [DW-1:0] rdata;
        time           t_acc;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_we;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_pattern = '0;
    logic          busy;
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    exp_t          sb[$];
    logic [DW-1:0] model [DEPTH];
    int            n_checks = 0;
    int            n_pass = 0;
    int            ce_cnt = 0;
    logic          stall_force = 1'b0;
    time           last_hs = 0;
    time           last_acc = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .fill_start(fill_start), .fill_pattern(fill_pattern), .busy(busy),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    single_port_ram #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) ram (
        .clk(clk), .nrst(nrst), .ce(ram_ce), .we(ram_we), .adr(ram_adr),
        .din(ram_din), .dout(ram_dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_we"}, 32'(rsp_we), 0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ram_ce"}, 32'(ram_ce), 0);
        check({tag, "_ram_we"}, 32'(ram_we), 0);
        check({tag, "_ram_adr"}, 32'(ram_adr), 0);
        check({tag, "_ram_din"}, 32'(ram_din), 0);
    endtask

    // Pulse reset starting at a negedge, releasing it well before the next rising edge.
    task automatic pulse_reset(input string tag);
        nrst = 1'b0;
        #1;
        check_reset_outputs(tag);
        #2;
        nrst = 1'b1;
        model_reset();
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy && req_ready && sb.size() == 0) break;
            n++;
            if (n > 200) begin
                fail_now("wait_idle");
                break;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        exp_t e;
        int   n = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                fail_now("req_accept");
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        e.t_acc  = $time;
        last_acc = $time;
        #1;
        req_valid = 1'b0;
        e.we  = we;
        e.err = int'(addr) >= int'(DEPTH);
        if (e.err) begin
            e.rdata = '0;
            e.lat   = 1;
        end else if (we) begin
            e.rdata = '0;
            e.lat   = 2;
            model[int'(addr)] = wdata;
        end else begin
            e.rdata = model[int'(addr)];
            e.lat   = 3;
        end
        sb.push_back(e);
    endtask

    // Starts a fill (with a competing command raised in the same cycle) and follows its sweep.
    task automatic do_fill(input logic [DW-1:0] pat, input int abort_at);
        int k = 0;
        wait_idle();
        @(posedge clk);
        #1;
        fill_start   = 1'b1;
        fill_pattern = pat;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = '0;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        req_valid  = 1'b0;
        for (int c = 0; c < 3 * int'(DEPTH); c++) begin
            @(negedge clk);
            if (!busy) break;
            if (k == 0) check("fill_prio_req_ready", 32'(req_ready), 0);
            check("fill_adr", 32'(ram_adr), 32'(k));
            check("fill_ce_we", {30'd0, ram_ce, ram_we}, 32'd3);
            check("fill_din", 32'(ram_din), 32'(pat));
            if (k == abort_at) begin
                pulse_reset("rst_mid_fill");
                return;
            end
            k++;
        end
        check("fill_busy_cycles", 32'(k), 32'(DEPTH));
        for (int i = 0; i < int'(DEPTH); i++) model[i] = pat;
    endtask

    always @(negedge clk) if (nrst && ram_ce) ce_cnt++;

    // Consumer back-pressure, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = stall_force ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on first appearance, stability while stalled, contents at handshake.
    initial begin
        logic          held = 1'b0;
        logic          p_we = 1'b0;
        logic          p_err = 1'b0;
        logic [DW-1:0] p_rdata = '0;
        exp_t          cur;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                held = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                check("req_ready_low_in_resp", 32'(req_ready), 0);
                if (!held) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 32'(rsp_valid), 0);
                    end else begin
                        cur = sb[0];
                        check("rsp_latency", 32'(($time + 5 - cur.t_acc) / 10), 32'(cur.lat));
                    end
                end else begin
                    check("stall_rdata", 32'(rsp_rdata), 32'(p_rdata));
                    check("stall_we_err", {30'd0, rsp_we, rsp_err}, {30'd0, p_we, p_err});
                end
                if (rsp_ready) begin
                    last_hs = $time;
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                        check("rsp_we", 32'(rsp_we), 32'(cur.we));
                        check("rsp_err", 32'(rsp_err), 32'(cur.err));
                        check("rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
                    end
                end
                p_we    = rsp_we;
                p_err   = rsp_err;
                p_rdata = rsp_rdata;
            end
            held = rsp_valid && !rsp_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_before;
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #3;
        nrst = 1'b1;

        // Directed write/read and untouched-location read.
        issue(1'b1, 8'd3, 8'hA5);
        issue(1'b0, 8'd3, 8'h00);
        issue(1'b0, 8'd5, 8'h00);

        // Fill, then read back every word.
        do_fill(8'h3C, -1);
        for (int a = 0; a < int'(DEPTH); a++) issue(1'b0, AW'(a), 8'h00);

        // Out-of-range commands must not touch the RAM.
        wait_idle();
        ce_before = ce_cnt;
        issue(1'b1, 8'd8, 8'h77);
        issue(1'b0, 8'd8, 8'h00);
        issue(1'b0, 8'hFF, 8'h00);
        wait_idle();
        check("err_no_ram_ce", 32'(ce_cnt - ce_before), 0);

        // Held-off read response with a command waiting behind it.
        wait_idle();
        stall_force = 1'b1;
        issue(1'b0, 8'd3, 8'h00);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) fail_now("stall_rsp_valid");
        fork
            issue(1'b1, 8'd6, 8'h5A);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_hold_valid", 32'(rsp_valid), 1);
                end
                @(posedge clk);
                #1;
                stall_force = 1'b0;
            end
        join
        check("accept_after_hs", 32'(last_acc >= last_hs + 15), 1);
        issue(1'b0, 8'd6, 8'h00);

        // Randomized traffic with occasional fills.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) do_fill(DW'($urandom), -1);
            else issue(1'($urandom), AW'($urandom_range(0, DEPTH + 3)), DW'($urandom));
        end

        // Reset in the middle of a fill.
        do_fill(8'hC3, 4);
        repeat (4) @(negedge clk);
        check_reset_outputs("after_fill_abort");
        issue(1'b0, 8'd2, 8'h00);
        issue(1'b0, 8'd6, 8'h00);

        // Reset while the read is waiting on RAM data.
        wait_idle();
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rd_issue_ce", 32'(ram_ce), 1);
        @(negedge clk);
        check("rd_wait_ce", 32'(ram_ce), 0);
        pulse_reset("rst_mid_read");
        repeat (6) begin
            @(negedge clk);
            check("no_rsp_after_reset", 32'(rsp_valid), 0);
        end
        check_reset_outputs("after_read_abort");
        issue(1'b0, 8'd2, 8'h00);

        wait_idle();
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Request-side controller that drives the single-port RAM's ce/we/adr/din pins and captures its registered dout. Accepts read/write commands on a valid/ready handshake and returns exactly one response per accepted command on a second valid/ready handshake. Also runs a background fill (scrub) of the whole RAM to a programmable pattern. Sits between a host/datapath and one single_port_ram instance.

Parameters:
DW, 8, data width of RAM words and request/response data
AW, 8, address width of RAM adr port
DEPTH, 8, number of implemented RAM words; legal addresses are 0..DEPTH-1

Ports:
clk  input  1  system clock, all logic on rising edge
nrst  input  1  asynchronous active-low reset
req_valid  input  1  command present
req_ready  output  1  controller can accept command this cycle
req_we  input  1  1=write, 0=read
req_addr  input  AW  command address
req_wdata  input  DW  write data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_we  output  1  echo of command type
rsp_err  output  1  1 = address out of range, RAM not accessed
rsp_rdata  output  DW  read data (0 for writes and errors)
fill_start  input  1  single-cycle pulse, start fill
fill_pattern  input  DW  word written to every location during fill
busy  output  1  state != IDLE
ram_ce  output  1  to RAM ce
ram_we  output  1  to RAM we
ram_adr  output  AW  to RAM adr
ram_din  output  DW  to RAM din
ram_dout  input  DW  from RAM dout (registered in RAM, 1-cycle latency)

Behaviour:
- All outputs registered. Reset (nrst low, any time, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_we=0, rsp_err=0, rsp_rdata=0, busy=0, ram_ce=0, ram_we=0, ram_adr=0, ram_din=0, fill counter=0. Reset mid-command/mid-fill aborts it; no response is produced.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, RESP, FILL.
- IDLE: req_ready=1. Accept when req_valid&req_ready. Priority: fill_start over req_valid in the same cycle (command not accepted, req_ready drops next cycle). fill_start outside IDLE is ignored.
- Accepted command with req_addr>=DEPTH -> RESP with rsp_err=1, rsp_rdata=0, rsp_we=req_we; RAM untouched.
- Write: WR for one cycle with ram_ce=1, ram_we=1, ram_adr/ram_din latched from the request -> RESP (rsp_we=1, rdata=0).
- Read: RD_ISSUE one cycle with ram_ce=1, ram_we=0, ram_adr latched -> RD_WAIT one cycle (ram_ce=0) -> sample ram_dout at end of RD_WAIT into rsp_rdata -> RESP. Accept-to-rsp_valid latency: read 3 cycles, write 2, error 1.
- RESP: rsp_valid=1, holds all rsp_* stable until rsp_ready; on handshake rsp_valid=0, state=IDLE, req_ready=1 next cycle. No new command accepted while in RESP (one outstanding max).
- ram_ce=0 in every state except WR, RD_ISSUE, FILL. ram_we=0 whenever ram_ce=0.
- FILL: counter 0..DEPTH-1, one word per cycle, ram_ce=1, ram_we=1, ram_adr=counter, ram_din=pattern latched at fill_start. After word DEPTH-1, return to IDLE; fill takes exactly DEPTH cycles; counter resets to 0. No response generated.
- busy=1 in every state other than IDLE.
- Address compare done at full AW width; no wrap-around of command addresses.

Decomposition:
- Package ram_ctrl_pkg: state enum (IDLE, WR, RD_ISSUE, RD_WAIT, RESP, FILL), default widths DW/AW/DEPTH.
- No sub-module in the controller. Bench top instantiates ram_access_ctrl plus single_port_ram with shared clk/nrst.

Test Plan:
- Reset then write 0xA5 to addr 3, read addr 3 -> write resp (rsp_we=1, err=0) 2 cycles after accept; read resp rdata=0xA5 exactly 3 cycles after accept.
- Read addr 5 after reset with no write -> rdata=0xFF (RAM reset value), err=0.
- fill_start with pattern 0x3C -> busy high exactly 8 cycles, ram_adr 0..7 in order; subsequent reads of addrs 0..7 all return 0x3C.
- Command at addr 8 (>=DEPTH) -> rsp_err=1, rdata=0, ram_ce never asserted.
- rsp_ready held low 5 cycles during read response -> rsp_valid/rdata stable; req_ready=0; new req_valid not accepted until the cycle after handshake.
- nrst pulsed low mid-fill (counter=4) and mid-read (RD_WAIT) -> all outputs return to reset values immediately; no rsp_valid afterwards; IDLE, req_ready=1.
